// File: rtl/feature_serializer.sv
`default_nettype none
// ============================================================================
//  feature_serializer
//  Snapshots one epoch's feature set and streams it as 32-bit words
//  (optional header first) over a valid/ready interface.
//  Revision: 1.0 - initial release
// ============================================================================
module feature_serializer #(
  parameter int       NUM_FEAT  = 27,
  parameter int       HEADER_EN = 1,
  parameter bit [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   feat_valid,
  input  logic [NUM_FEAT*32-1:0] feat_in,
  output logic [31:0]            m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic [4:0]             m_index,
  output logic                   busy,
  output logic [15:0]            frame_cnt,
  output logic [15:0]            drop_cnt,
  output logic                   overrun
);

  localparam int       c_len  = NUM_FEAT + HEADER_EN;
  localparam bit [4:0] c_last = 5'(c_len - 1);

  typedef logic [NUM_FEAT-1:0][31:0] bank_t;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t      r_state, w_state_nxt;
  bank_t       r_shadow, w_bank_nxt, w_feat_arr;
  logic [15:0] r_hdr_cnt, w_hdr_nxt;
  logic [15:0] r_frame_cnt, r_drop_cnt;
  logic        r_overrun;
  logic [4:0]  r_idx, w_idx_nxt;
  logic        r_valid, w_valid_nxt;
  logic        r_last, w_last_nxt;
  logic [31:0] r_data, w_data_nxt;
  logic        w_fire, w_xfer, w_capture, w_drop, w_go_idle;

  // Word w of a frame: header at w=0 when enabled, otherwise feature w-HEADER_EN.
  function automatic logic [31:0] f_word(input logic [4:0] idx, input bank_t bank,
                                         input logic [15:0] hdr);
    if (HEADER_EN != 0 && idx == 5'd0)
      return {SYNC_BYTE, 8'(NUM_FEAT), hdr};
    return bank[idx - 5'(HEADER_EN)];
  endfunction

  assign w_feat_arr = feat_in;
  assign w_fire     = feat_valid && en;
  assign w_xfer     = r_valid && m_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_valid_nxt = r_valid;
    w_hdr_nxt   = r_hdr_cnt;
    w_capture   = 1'b0;
    w_drop      = 1'b0;
    w_go_idle   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_fire) w_capture = 1'b1;
      end
      S_SEND: begin
        if (w_xfer && r_last) begin
          if (w_fire) w_capture = 1'b1;
          else        w_go_idle = 1'b1;
        end else begin
          if (w_xfer) w_idx_nxt = r_idx + 5'd1;
          if (w_fire) w_drop = 1'b1;
        end
      end
      default: w_go_idle = 1'b1;
    endcase

    if (w_capture) begin
      w_state_nxt = S_SEND;
      w_idx_nxt   = 5'd0;
      w_valid_nxt = 1'b1;
      w_hdr_nxt   = r_frame_cnt;
    end
    if (w_go_idle) begin
      w_state_nxt = S_IDLE;
      w_idx_nxt   = 5'd0;
      w_valid_nxt = 1'b0;
    end

    // Output word is re-derived every cycle, so it holds naturally during stalls.
    w_bank_nxt = w_capture ? w_feat_arr : r_shadow;
    w_last_nxt = w_valid_nxt && (w_idx_nxt == c_last);
    w_data_nxt = w_valid_nxt ? f_word(w_idx_nxt, w_bank_nxt, w_hdr_nxt) : 32'd0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_shadow    <= '0;
      r_hdr_cnt   <= 16'd0;
      r_frame_cnt <= 16'd0;
      r_drop_cnt  <= 16'd0;
      r_overrun   <= 1'b0;
      r_idx       <= 5'd0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_data      <= 32'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_shadow  <= w_bank_nxt;
      r_hdr_cnt <= w_hdr_nxt;
      r_idx     <= w_idx_nxt;
      r_valid   <= w_valid_nxt;
      r_last    <= w_last_nxt;
      r_data    <= w_data_nxt;
      if (w_capture) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_drop) begin
        r_overrun <= 1'b1;
        if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  assign m_data    = r_data;
  assign m_valid   = r_valid;
  assign m_last    = r_last;
  assign m_index   = r_idx;
  assign busy      = (r_state == S_SEND);
  assign frame_cnt = r_frame_cnt;
  assign drop_cnt  = r_drop_cnt;
  assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_feature_serializer.sv
`default_nettype none
// ============================================================================
//  tb_feature_serializer
//  Randomized and directed bench; header and headerless builds run side by side.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_feature_serializer;

  localparam int c_nf = 27;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              en = 1'b0;
  logic              feat_valid = 1'b0;
  logic [c_nf*32-1:0] feat_in = '0;
  logic              m_ready = 1'b0;

  logic [31:0] h1_data, h0_data;
  logic        h1_valid, h0_valid, h1_last, h0_last, h1_busy, h0_busy, h1_over, h0_over;
  logic [4:0]  h1_index, h0_index;
  logic [15:0] h1_frame, h0_frame, h1_drop, h0_drop;

  int n_total = 0;
  int n_bad   = 0;
  bit chk_on  = 1'b0;

  always #5 clk = ~clk;

  feature_serializer #(.NUM_FEAT(c_nf), .HEADER_EN(1), .SYNC_BYTE(8'hA5)) u_dut_h1 (
    .clk(clk), .rst(rst), .en(en), .feat_valid(feat_valid), .feat_in(feat_in),
    .m_data(h1_data), .m_valid(h1_valid), .m_ready(m_ready), .m_last(h1_last),
    .m_index(h1_index), .busy(h1_busy), .frame_cnt(h1_frame), .drop_cnt(h1_drop),
    .overrun(h1_over));

  feature_serializer #(.NUM_FEAT(c_nf), .HEADER_EN(0), .SYNC_BYTE(8'hA5)) u_dut_h0 (
    .clk(clk), .rst(rst), .en(en), .feat_valid(feat_valid), .feat_in(feat_in),
    .m_data(h0_data), .m_valid(h0_valid), .m_ready(m_ready), .m_last(h0_last),
    .m_index(h0_index), .busy(h0_busy), .frame_cnt(h0_frame), .drop_cnt(h0_drop),
    .overrun(h0_over));

  task automatic chk_val(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of words; a pointer walks it as transfers happen.
  logic [31:0] mw [2][28];
  bit          mbusy [2];
  int          mpos [2];
  logic [15:0] mframe [2];
  logic [15:0] mdrop [2];
  bit          mover [2];

  task automatic model_reset();
    for (int h = 0; h < 2; h++) begin
      mbusy[h] = 0; mpos[h] = 0; mframe[h] = 0; mdrop[h] = 0; mover[h] = 0;
    end
  endtask

  task automatic model_step(input int h);
    int len;
    bit fire, xfer, endf;
    len  = c_nf + h;
    fire = feat_valid && en;
    xfer = mbusy[h] && m_ready;
    endf = xfer && (mpos[h] == len - 1);
    if (mbusy[h] && fire && !endf) begin
      if (mdrop[h] != 16'hFFFF) mdrop[h] = mdrop[h] + 16'd1;
      mover[h] = 1;
    end
    if (xfer) begin
      if (endf) mbusy[h] = 0;
      else      mpos[h]  = mpos[h] + 1;
    end
    if (fire && !mbusy[h]) begin
      if (h == 1) mw[h][0] = {8'hA5, 8'd27, mframe[h]};
      for (int k = 0; k < c_nf; k++) mw[h][k + h] = feat_in[k*32 +: 32];
      mframe[h] = mframe[h] + 16'd1;
      mbusy[h]  = 1;
      mpos[h]   = 0;
    end
  endtask

  function automatic logic [79:0] exp_bundle(input int h);
    logic [31:0] d;
    logic [4:0]  ix;
    bit          lst;
    d   = mbusy[h] ? mw[h][mpos[h]] : 32'd0;
    ix  = mbusy[h] ? 5'(mpos[h]) : 5'd0;
    lst = mbusy[h] && (mpos[h] == c_nf + h - 1);
    return {7'd0, mbusy[h], lst, mbusy[h], mover[h], ix, d, mframe[h], mdrop[h]};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk_val("cyc_h1", {7'd0, h1_valid, h1_last, h1_busy, h1_over, h1_index, h1_data,
                         h1_frame, h1_drop}, exp_bundle(1));
      chk_val("cyc_h0", {7'd0, h0_valid, h0_last, h0_busy, h0_over, h0_index, h0_data,
                         h0_frame, h0_drop}, exp_bundle(0));
    end
  end

  // All tasks below start and end on a falling clock edge.
  task automatic do_reset();
    #2 rst = 1'b0;
    feat_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic set_ramp(input logic [31:0] base);
    for (int k = 0; k < c_nf; k++) feat_in[k*32 +: 32] = base + 32'(k);
  endtask

  task automatic pulse();
    feat_valid = 1'b1;
    @(negedge clk);
    feat_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (h1_busy && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk_val(tag, 80'(h1_busy), 80'd0);
  endtask

  initial begin
    int c, n;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    chk_on = 1'b1;

    // Basic frame
    chk_val("rst_valid", 80'(h1_valid), 80'd0);
    chk_val("rst_frame", 80'(h1_frame), 80'd0);
    en = 1'b1; m_ready = 1'b1;
    set_ramp(32'h1000);
    pulse();
    chk_val("hdr0", 80'(h1_data), 80'hA51B0000);
    chk_val("hdr0_idx", 80'(h1_index), 80'd0);
    for (int w = 1; w <= 27; w++) begin
      @(negedge clk);
      chk_val("w_data", 80'(h1_data), 80'(32'h1000 + 32'(w - 1)));
      chk_val("w_idx_last", {74'd0, h1_index, h1_last}, {74'd0, 5'(w), (w == 27)});
    end
    @(negedge clk);
    chk_val("busy_after", 80'(h1_busy), 80'd0);

    // Toggling ready
    do_reset();
    pulse();
    c = 0;
    while (c < 200) begin
      m_ready = (c % 2 == 0);
      if (h1_valid && h1_last && m_ready) break;
      @(negedge clk);
      c++;
    end
    chk_val("toggle_len", 80'(c + 1), 80'd55);
    @(negedge clk);
    m_ready = 1'b1;
    wait_idle("idle_to1");
    pulse();
    for (int i = 0; i < 40; i++) begin
      m_ready = !(i >= 10 && i < 15) && (i % 3 != 2);
      @(negedge clk);
    end
    m_ready = 1'b1;
    wait_idle("idle_to2");

    // Overrun drop
    do_reset();
    set_ramp(32'h1000);
    pulse();
    repeat (9) @(negedge clk);
    set_ramp(32'h2000);
    pulse();
    wait_idle("idle_to3");
    chk_val("drop1", 80'(h1_drop), 80'd1);
    chk_val("over1", 80'(h1_over), 80'd1);
    chk_val("frame1", 80'(h1_frame), 80'd1);
    pulse();
    chk_val("hdr_cnt1", 80'(h1_data), 80'hA51B0001);
    wait_idle("idle_to4");

    // Back-to-back capture on the last transfer
    do_reset();
    set_ramp(32'h1000);
    pulse();
    n = 0;
    while (!h1_last && n < 100) begin @(negedge clk); n++; end
    set_ramp(32'hFFFF_FF00);
    pulse();
    chk_val("b2b_idx", 80'(h1_index), 80'd0);
    chk_val("b2b_hdr", 80'(h1_data), 80'hA51B0001);
    chk_val("b2b_drop", 80'(h1_drop), 80'd0);
    @(negedge clk);
    chk_val("b2b_w1", 80'(h1_data), 80'hFFFF_FF00);
    wait_idle("idle_to5");

    // Asynchronous reset mid-frame
    do_reset();
    set_ramp(32'h1000);
    pulse();
    n = 0;
    while (h1_index != 5'd12 && n < 100) begin @(negedge clk); n++; end
    #2 rst = 1'b0;
    #1 chk_val("arst_out", {77'd0, h1_valid, h1_last, h1_busy}, 80'd0);
    @(negedge clk);
    rst = 1'b1;
    chk_val("arst_frame", 80'(h1_frame), 80'd0);
    pulse();
    chk_val("arst_hdr", 80'(h1_data), 80'hA51B0000);
    wait_idle("idle_to6");

    // Headerless build, en gating and negative features
    do_reset();
    en = 1'b0;
    for (int k = 0; k < c_nf; k++) feat_in[k*32 +: 32] = 32'h8000_0001 + 32'(k << 8);
    pulse();
    repeat (2) @(negedge clk);
    chk_val("en0_busy", 80'(h0_busy), 80'd0);
    chk_val("en0_drop", 80'(h0_drop), 80'd0);
    en = 1'b1;
    pulse();
    for (int w = 0; w < 27; w++) begin
      chk_val("h0_data", 80'(h0_data), 80'(32'h8000_0001 + 32'(w << 8)));
      chk_val("h0_idx_last", {74'd0, h0_index, h0_last}, {74'd0, 5'(w), (w == 26)});
      @(negedge clk);
    end
    chk_val("h0_idle", 80'(h0_busy), 80'd0);
    wait_idle("idle_to7");

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 1499) == 0) begin
        do_reset();
      end
      feat_valid = ($urandom_range(0, 24) == 0);
      en         = ($urandom_range(0, 7) != 0);
      m_ready    = ($urandom_range(0, 3) != 0);
      if (feat_valid)
        for (int k = 0; k < c_nf; k++) feat_in[k*32 +: 32] = $urandom;
      @(negedge clk);
    end
    feat_valid = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/feature_serializer.md
Name: feature_serializer

Overview:
- Sits directly downstream of feature_extraction_top.
- On each feature-valid pulse it snapshots the 27 epoch features into a shadow register bank.
- It then streams them, optionally preceded by a header word, as 32-bit words over a valid/ready stream to the classifier or UART bridge.
- It decouples the classifier's pace from the feature extractor and reports epochs lost to back-pressure.

Parameters:
- NUM_FEAT, 27, number of 32-bit features per frame (fixed order below).
- HEADER_EN, 1, 1 = prepend one header word per frame; 0 = features only.
- SYNC_BYTE, 8'hA5, marker placed in header bits [31:24].

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  capture enable.
- feat_valid  in  1  single-cycle pulse: feat_in holds a complete, new feature set.
- feat_in  in  NUM_FEAT*32  packed features; feature k occupies [32k+31:32k].
- m_data  out  32  stream word.
- m_valid  out  1  m_data valid.
- m_ready  in  1  consumer accepts word.
- m_last  out  1  high with the final word of a frame.
- m_index  out  5  word index within the frame (header = 0 when HEADER_EN=1).
- busy  out  1  frame held or in transmission.
- frame_cnt  out  16  frames captured, wraps.
- drop_cnt  out  16  frames dropped, saturates at 16'hFFFF.
- overrun  out  1  sticky: at least one frame dropped.

Behaviour:
- Feature order, k = 0..26:
  - psd gamma, beta, alpha, theta, delta (k = 0..4)
  - peak_amplitude (k = 5)
  - zero_counter, zero-extended to 32 bits by the upstream stage (k = 6)
  - dwt gamma/beta/alpha/theta/delta, each as max, min, mean, sum (k = 7..26)
- Reset (rst=0, asynchronous): m_valid=0, m_data=0, m_last=0, m_index=0, busy=0, frame_cnt=0, drop_cnt=0, overrun=0, FSM=IDLE, shadow bank cleared.
- FSM states:
  - IDLE: feat_valid && en → capture feat_in into shadow bank, latch hdr_cnt=frame_cnt, frame_cnt+1, go to SEND. feat_valid with en=0 is ignored and not counted as a drop.
  - SEND: m_valid=1, busy=1. Word w is the header when HEADER_EN=1 and w=0; otherwise it is feature (w - HEADER_EN).
  - Frame length is L = NUM_FEAT + HEADER_EN (28 by default).
- Header word = {SYNC_BYTE, 8'(NUM_FEAT), hdr_cnt[15:0]}. The first frame after reset carries 0.
- Latency: m_valid rises on the clock edge that captures the set, so the first word is presented in the cycle after the feat_valid cycle.
- Handshake:
  - A transfer occurs on a rising edge with m_valid && m_ready.
  - m_data, m_index and m_last are registered and must stay stable while m_valid && !m_ready.
  - m_valid never drops mid-frame.
  - One word per cycle when m_ready is held high, so a frame takes L cycles minimum.
- m_last=1 only while m_index = L-1.
- Transfer of the last word → IDLE, m_valid=0, busy=0. Exception: back-to-back capture (below).
- Back-to-back: feat_valid && en in the same cycle as the last-word transfer captures the new set and stays in SEND with m_index=0. No drop, no idle cycle.
- Overrun: feat_valid in SEND other than on the last-word transfer cycle drops the new set.
  - drop_cnt increments (saturating) and overrun=1 (sticky until reset).
  - The frame in flight is neither altered nor restarted.
  - frame_cnt is not incremented.
- en deasserted mid-frame does not abort; the frame completes. en only gates new captures.
- Reset asserted mid-frame: immediate abort, all outputs to reset values, partial frame not resumed.
- Arithmetic: the block only moves data; features pass bit-exact with no sign change. frame_cnt wraps 16'hFFFF→0.

Test Plan:
- Reset, en=1, one feat_valid with feature k = 32'h1000+k, m_ready=1 → next cycle header 32'hA51B0000 at m_index 0. Then 27 consecutive words 32'h1000..32'h101A, m_last only on m_index 27, busy low the cycle after.
- Same frame with m_ready toggling 1/0 each cycle (and a 5-cycle low stall mid-frame) → words and order identical, m_data/m_index held stable during stalls, frame takes 55 cycles.
- Second feat_valid 10 cycles into a frame → in-flight frame unchanged, drop_cnt=1, overrun=1, frame_cnt=1. Next accepted frame header low half = 0x0001.
- feat_valid coincident with last-word transfer, with features 32'hFFFF_FF00+k → m_index returns to 0 next cycle with header count 1, no idle cycle, drop_cnt=0.
- rst pulled low at m_index 12 (asynchronous, mid-cycle) → m_valid/m_last/busy low immediately. After release, frame_cnt=0 and the next frame header = 32'hA51B0000.
- HEADER_EN=0 build, feat_valid with en=0 then en=1 → first pulse ignored (drop_cnt=0). Second yields 27 words, m_index 0..26, m_last at 26, negative features (e.g. 32'h8000_0001) passed unchanged.
